mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one 32-bit memory port among NUM_CORES requesters.
// Optional BUSY watchdog with sticky bus_err is enabled by defining MEM_ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int unsigned NUM_CORES      = 2,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CORES-1:0]    core_mem_read,
  input  logic [NUM_CORES-1:0]    core_mem_write,
  input  logic [32*NUM_CORES-1:0] core_mem_addr,
  input  logic [32*NUM_CORES-1:0] core_mem_data_w,
  output logic [32*NUM_CORES-1:0] core_mem_data_r,
  output logic [NUM_CORES-1:0]    core_mem_wait,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [31:0]             mem_addr,
  output logic [31:0]             mem_data_w,
  input  logic [31:0]             mem_data_r,
  input  logic                    mem_ready,
  output logic                    bus_err
);

  localparam int unsigned DW = 32;
  localparam int unsigned GW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q, last_grant_q, sel, idx;
  logic [NUM_CORES-1:0] pending;
  logic            any_pending, found, timeout, complete;
  logic [DW-1:0]   addr_a  [NUM_CORES];
  logic [DW-1:0]   wdata_a [NUM_CORES];
  logic [DW-1:0]   rdata_q [NUM_CORES];

  if (NUM_CORES < 2 || NUM_CORES > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("mem_arbiter: NUM_CORES must be 2..8 and TIMEOUT_CYCLES at least 1");
  end

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
    assign addr_a[i]                  = core_mem_addr[DW*i +: DW];
    assign wdata_a[i]                 = core_mem_data_w[DW*i +: DW];
    assign core_mem_data_r[DW*i +: DW] = rdata_q[i];
  end

  assign pending     = core_mem_read | core_mem_write;
  assign any_pending = |pending;
  assign complete    = (state_q == BUSY) && (mem_ready || timeout);

  // Release exactly the granted core during DONE; everyone else stalls on its own request.
  always_comb begin
    core_mem_wait = pending;
    if (state_q == DONE) core_mem_wait[grant_q] = 1'b0;
  end

  // Round-robin pick, starting just after the last served core.
  always_comb begin
    sel   = last_grant_q;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= NUM_CORES; k++) begin
      idx = GW'((32'(last_grant_q) + k) % NUM_CORES);
      if (!found && pending[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wdog_q;
  logic          bus_err_q;

  assign timeout = (state_q == BUSY) && !mem_ready && (wdog_q == CW'(TIMEOUT_CYCLES - 1));
  assign bus_err = bus_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      if (state_q != BUSY)  wdog_q <= '0;
      else if (!mem_ready)  wdog_q <= wdog_q + CW'(1);
      if (timeout)          bus_err_q <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_pending) state_d = BUSY;
      BUSY:    if (mem_ready || timeout) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latched request drives the memory port for the whole BUSY window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_CORES - 1);
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_addr     <= '0;
      mem_data_w   <= '0;
      for (int i = 0; i < NUM_CORES; i++) rdata_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: if (any_pending) begin
          grant_q    <= sel;
          mem_addr   <= addr_a[sel];
          mem_data_w <= wdata_a[sel];
          mem_write  <= core_mem_write[sel];
          mem_read   <= ~core_mem_write[sel];
        end
        BUSY: if (complete) begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          if (!mem_write) rdata_q[grant_q] <= mem_ready ? mem_data_r : 32'hDEADBEEF;
        end
        DONE:    last_grant_q <= grant_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with three cores: table of transactions plus reset and long-wait sequences.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int unsigned NC = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [NC-1:0]   core_mem_read, core_mem_write, core_mem_wait;
  logic [NC*32-1:0] core_mem_addr, core_mem_data_w, core_mem_data_r;
  logic            mem_read, mem_write, mem_ready, bus_err;
  logic [31:0]     mem_addr, mem_data_w, mem_data_r;

  always #5 clk = ~clk;

  mem_arbiter #(.NUM_CORES(NC), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .core_mem_read(core_mem_read), .core_mem_write(core_mem_write),
    .core_mem_addr(core_mem_addr), .core_mem_data_w(core_mem_data_w),
    .core_mem_data_r(core_mem_data_r), .core_mem_wait(core_mem_wait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_data_w(mem_data_w), .mem_data_r(mem_data_r), .mem_ready(mem_ready),
    .bus_err(bus_err)
  );

  typedef struct packed {
    logic [2:0]       rd;
    logic [2:0]       wr;
    logic [2:0][31:0] addr;
    logic [2:0][31:0] wdata;
    logic [4:0]       dly;
    logic [31:0]      rdata;
    logic [1:0]       core;
    logic             ewr;
    logic [31:0]      eaddr;
    logic [31:0]      ewdata;
  } vec_t;

  int               passed = 0;
  int               total  = 0;
  logic [2:0][31:0] exp_dr;
  logic             exp_bus_err;
  vec_t             vecs [10];

  function automatic vec_t mk(input logic [2:0] rd, input logic [2:0] wr,
                              input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                              input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                              input int dly, input logic [31:0] rdata, input int core, input logic ewr,
                              input logic [31:0] eaddr, input logic [31:0] ewdata);
    vec_t v;
    v.rd = rd; v.wr = wr;
    v.addr[0] = a0; v.addr[1] = a1; v.addr[2] = a2;
    v.wdata[0] = d0; v.wdata[1] = d1; v.wdata[2] = d2;
    v.dly = 5'(dly); v.rdata = rdata; v.core = 2'(core); v.ewr = ewr;
    v.eaddr = eaddr; v.ewdata = ewdata;
    return v;
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Entered at a negedge with the FSM in IDLE; leaves at the negedge after DONE (IDLE again).
  task automatic run_vec(input vec_t v, input string tag);
    logic [2:0] req, done_wait;
    req = v.rd | v.wr;
    core_mem_read   = v.rd;
    core_mem_write  = v.wr;
    core_mem_addr   = v.addr;
    core_mem_data_w = v.wdata;
    #1;
    check({tag, " idle_wait"}, 96'(core_mem_wait), 96'(req));
    check({tag, " idle_strobe"}, 96'({mem_read, mem_write}), 96'(0));
    for (int c = 0; c <= int'(v.dly); c++) begin
      @(negedge clk);
      check({tag, " busy_rd"}, 96'(mem_read), 96'(!v.ewr));
      check({tag, " busy_wr"}, 96'(mem_write), 96'(v.ewr));
      check({tag, " busy_addr"}, 96'(mem_addr), 96'(v.eaddr));
      check({tag, " busy_wdata"}, 96'(mem_data_w), 96'(v.ewdata));
      check({tag, " busy_wait"}, 96'(core_mem_wait), 96'(req));
      check({tag, " busy_err"}, 96'(bus_err), 96'(exp_bus_err));
      if (c == int'(v.dly)) begin
        mem_ready  = 1'b1;
        mem_data_r = v.rdata;
      end
    end
    @(negedge clk);
    mem_ready  = 1'b0;
    mem_data_r = 32'h0BAD0BAD;
    done_wait = req;
    done_wait[v.core] = 1'b0;
    if (!v.ewr) exp_dr[v.core] = v.rdata;
    check({tag, " done_wait"}, 96'(core_mem_wait), 96'(done_wait));
    check({tag, " done_strobe"}, 96'({mem_read, mem_write}), 96'(0));
    check({tag, " done_data"}, core_mem_data_r, exp_dr);
    core_mem_read[v.core]  = 1'b0;
    core_mem_write[v.core] = 1'b0;
    @(negedge clk);
    check({tag, " idle_after"}, 96'({mem_read, mem_write}), 96'(0));
    check({tag, " hold_data"}, core_mem_data_r, exp_dr);
  endtask

  initial begin
    vecs[0] = mk(3'b001, 3'b000, 32'h100, 32'h0,   32'h0,   32'h0, 32'h0, 32'h0, 0, 32'h12345678, 0, 1'b0, 32'h100, 32'h0);
    vecs[1] = mk(3'b011, 3'b000, 32'h104, 32'h108, 32'h0,   32'h0, 32'h0, 32'h0, 1, 32'hA1A1A1A1, 1, 1'b0, 32'h108, 32'h0);
    vecs[2] = mk(3'b011, 3'b000, 32'h104, 32'h10C, 32'h0,   32'h0, 32'h0, 32'h0, 0, 32'hB2B2B2B2, 0, 1'b0, 32'h104, 32'h0);
    vecs[3] = mk(3'b000, 3'b010, 32'h0,   32'h200, 32'h0,   32'h0, 32'hCAFEF00D, 32'h0, 4, 32'h55555555, 1, 1'b1, 32'h200, 32'hCAFEF00D);
    vecs[4] = mk(3'b100, 3'b100, 32'h0,   32'h0,   32'h300, 32'h0, 32'h0, 32'h77778888, 2, 32'h99999999, 2, 1'b1, 32'h300, 32'h77778888);
    vecs[5] = mk(3'b101, 3'b000, 32'h400, 32'h0,   32'h404, 32'h0, 32'h0, 32'h0, 0, 32'hC0C0C0C0, 0, 1'b0, 32'h400, 32'h0);
    vecs[6] = mk(3'b110, 3'b000, 32'h0,   32'h500, 32'h404, 32'h0, 32'h0, 32'h0, 3, 32'hD1D1D1D1, 1, 1'b0, 32'h500, 32'h0);
    vecs[7] = mk(3'b100, 3'b000, 32'h0,   32'h0,   32'h404, 32'h0, 32'h0, 32'h0, 0, 32'hE2E2E2E2, 2, 1'b0, 32'h404, 32'h0);
    vecs[8] = mk(3'b001, 3'b011, 32'h600, 32'h604, 32'h0,   32'h11112222, 32'h33334444, 32'h0, 1, 32'h66666666, 0, 1'b1, 32'h600, 32'h11112222);
    vecs[9] = mk(3'b000, 3'b010, 32'h0,   32'h604, 32'h0,   32'h0, 32'h33334444, 32'h0, 0, 32'h77777777, 1, 1'b1, 32'h604, 32'h33334444);

    rst = 1'b1;
    core_mem_read = '0; core_mem_write = '0; core_mem_addr = '0; core_mem_data_w = '0;
    mem_ready = 1'b0; mem_data_r = 32'h0BAD0BAD;
    exp_dr = '0; exp_bus_err = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rd", 96'(mem_read), 96'(0));
    check("rst_wr", 96'(mem_write), 96'(0));
    check("rst_addr", 96'(mem_addr), 96'(0));
    check("rst_wdata", 96'(mem_data_w), 96'(0));
    check("rst_data_r", core_mem_data_r, 96'(0));
    check("rst_wait", 96'(core_mem_wait), 96'(0));
    check("rst_err", 96'(bus_err), 96'(0));
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Reset in the middle of BUSY: strobes drop at once, no DONE release for core 1.
    core_mem_read = 3'b010; core_mem_write = '0;
    core_mem_addr = {32'h0, 32'h700, 32'h0}; core_mem_data_w = '0;
    @(negedge clk);
    check("abort_busy_rd", 96'(mem_read), 96'(1));
    check("abort_busy_addr", 96'(mem_addr), 96'(32'h700));
    #2 rst = 1'b1;
    #1;
    exp_dr = '0;
    check("abort_rd", 96'(mem_read), 96'(0));
    check("abort_wr", 96'(mem_write), 96'(0));
    check("abort_addr", 96'(mem_addr), 96'(0));
    check("abort_data_r", core_mem_data_r, exp_dr);
    check("abort_wait", 96'(core_mem_wait), 96'(3'b010));
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("abort_no_pulse", 96'(core_mem_wait), 96'(3'b010));
    end
    rst = 1'b0;
    run_vec(mk(3'b011, 3'b000, 32'h800, 32'h700, 32'h0, 32'h0, 32'h0, 32'h0, 0, 32'hF0F0F0F0, 0, 1'b0, 32'h800, 32'h0), "rr0");
    run_vec(mk(3'b011, 3'b000, 32'h800, 32'h700, 32'h0, 32'h0, 32'h0, 32'h0, 1, 32'hF1F1F1F1, 1, 1'b0, 32'h700, 32'h0), "rr1");
    run_vec(mk(3'b011, 3'b000, 32'h804, 32'h700, 32'h0, 32'h0, 32'h0, 32'h0, 0, 32'hF2F2F2F2, 0, 1'b0, 32'h804, 32'h0), "rr2");
    run_vec(mk(3'b011, 3'b000, 32'h804, 32'h704, 32'h0, 32'h0, 32'h0, 32'h0, 0, 32'hF3F3F3F3, 1, 1'b0, 32'h704, 32'h0), "rr3");

`ifdef MEM_ARB_TIMEOUT_EN
    // Memory never answers: watchdog ends the access after 16 BUSY cycles.
    core_mem_read = 3'b001; core_mem_write = '0;
    core_mem_addr = {32'h0, 32'h0, 32'h900}; core_mem_data_w = '0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      check("wd_busy", 96'(mem_read), 96'(1));
    end
    @(negedge clk);
    exp_dr[0] = 32'hDEADBEEF;
    exp_bus_err = 1'b1;
    check("wd_wait", 96'(core_mem_wait), 96'(0));
    check("wd_data", core_mem_data_r, exp_dr);
    check("wd_err", 96'(bus_err), 96'(1));
    core_mem_read = '0;
    @(negedge clk);
    run_vec(mk(3'b010, 3'b000, 32'h0, 32'hA00, 32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h12121212, 1, 1'b0, 32'hA00, 32'h0), "wd_post");
    rst = 1'b1;
    #1;
    check("wd_err_clear", 96'(bus_err), 96'(0));
    exp_bus_err = 1'b0;
    @(negedge clk);
    rst = 1'b0;
`else
    // Without the watchdog a slow memory simply stretches BUSY.
    run_vec(mk(3'b001, 3'b000, 32'h900, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 20, 32'h13579BDF, 0, 1'b0, 32'h900, 32'h0), "slow");
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
